// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 MDIO frame engine executing single-register reads/writes.
//
// state | meaning
// IDLE  | mdc low, mdio released, waiting for a request
// PRE   | 32 preamble ones
// CMD   | ST, OP, PHYAD, REGAD (14 bits)
// TA    | turnaround: write drives 10, read releases mdio
// DATA  | 16 data bits, driven on write, sampled on read
// FIN   | one-cycle done / data_valid strobe
module mdio_master #(
   parameter int REF_CLK = 50,
   parameter int MDC_CLK = 500
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mdc,
   inout  wire         mdio,
   input  logic [4:0]  phy_addr,
   input  logic [4:0]  reg_addr,
   input  logic        write_req,
   input  logic [15:0] write_data,
   input  logic        read_req,
   output logic [15:0] read_data,
   output logic        data_valid,
   output logic        done,
   output logic        busy,
   output logic        ta_err
);
   localparam int HALF = REF_CLK * 1000 / (2 * MDC_CLK);
   localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

   generate
      if (HALF < 2) begin : g_half_check
         $error("mdio_master: MDC half-period must be at least 2 clk cycles");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, PRE, CMD, TA, DATA, FIN} state_t;

   state_t        state, state_d;
   logic [DW-1:0] div_cnt, div_d;
   logic [5:0]    bit_cnt, bit_d;
   logic          mdc_d;
   logic          mdio_oe, oe_d;
   logic          mdio_o, o_d;
   logic          is_rd, is_rd_d;
   logic [31:0]   tx_sr, tx_d;
   logic [15:0]   rx_sr, rx_d, rdata_d;
   logic          sync1, sync2;
   logic          dv_d, done_d, busy_d, ta_d;
   logic          half_tc, bit_end, sample_pt;

   assign mdio = mdio_oe ? mdio_o : 1'bz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         mdc        <= 1'b0;
         mdio_oe    <= 1'b0;
         mdio_o     <= 1'b1;
         is_rd      <= 1'b0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         read_data  <= '0;
         data_valid <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         ta_err     <= 1'b0;
      end else begin
         state      <= state_d;
         div_cnt    <= div_d;
         bit_cnt    <= bit_d;
         mdc        <= mdc_d;
         mdio_oe    <= oe_d;
         mdio_o     <= o_d;
         is_rd      <= is_rd_d;
         tx_sr      <= tx_d;
         rx_sr      <= rx_d;
         sync1      <= mdio;
         sync2      <= sync1;
         read_data  <= rdata_d;
         data_valid <= dv_d;
         done       <= done_d;
         busy       <= busy_d;
         ta_err     <= ta_d;
      end
   end

   always_comb begin
      state_d   = state;
      div_d     = div_cnt;
      bit_d     = bit_cnt;
      mdc_d     = mdc;
      oe_d      = mdio_oe;
      o_d       = mdio_o;
      is_rd_d   = is_rd;
      tx_d      = tx_sr;
      rx_d      = rx_sr;
      rdata_d   = read_data;
      dv_d      = 1'b0;
      done_d    = 1'b0;
      busy_d    = busy;
      ta_d      = ta_err;
      half_tc   = (div_cnt == '0);
      bit_end   = mdc && half_tc;
      // sync2 lags mdio by two edges, so this picks up the value present at the mdc rise
      sample_pt = mdc && (div_cnt == DW'(HALF - 2));

      case (state)
         IDLE: begin
            mdc_d = 1'b0;
            oe_d  = 1'b0;
            if (write_req || read_req) begin
               state_d = PRE;
               is_rd_d = ~write_req;
               tx_d    = {2'b01, (write_req ? 2'b01 : 2'b10), phy_addr, reg_addr, 2'b10, write_data};
               bit_d   = 6'd31;
               div_d   = DW'(HALF - 1);
               oe_d    = 1'b1;
               o_d     = 1'b1;
               busy_d  = 1'b1;
            end
         end
         PRE, CMD, TA, DATA: begin
            if (half_tc) begin
               div_d = DW'(HALF - 1);
               mdc_d = ~mdc;
            end else begin
               div_d = div_cnt - 1'b1;
            end
            if (sample_pt && is_rd) begin
               if (state == TA && bit_cnt == '0) ta_d = sync2;
               if (state == DATA) rx_d = {rx_sr[14:0], sync2};
            end
            if (bit_end) begin
               if (state != PRE || bit_cnt == '0) begin
                  o_d  = tx_sr[31];
                  tx_d = {tx_sr[30:0], 1'b0};
               end
               if (bit_cnt != '0) begin
                  bit_d = bit_cnt - 1'b1;
               end else begin
                  case (state)
                     PRE: begin
                        state_d = CMD;
                        bit_d   = 6'd13;
                     end
                     CMD: begin
                        state_d = TA;
                        bit_d   = 6'd1;
                        if (is_rd) oe_d = 1'b0;
                     end
                     TA: begin
                        state_d = DATA;
                        bit_d   = 6'd15;
                     end
                     default: begin
                        state_d = FIN;
                        oe_d    = 1'b0;
                        done_d  = 1'b1;
                        if (is_rd) begin
                           dv_d    = 1'b1;
                           rdata_d = rx_d;
                        end
                     end
                  endcase
               end
            end
         end
         FIN: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: scoreboard bench for mdio_master with a behavioural PHY on the MDIO bus.
module tb_mdio_master;
   logic        clk = 1'b0;
   logic        rst;
   logic        mdc;
   wire         mdio;
   logic [4:0]  phy_addr, reg_addr;
   logic        write_req, read_req;
   logic [15:0] write_data;
   logic [15:0] read_data;
   logic        data_valid, done, busy, ta_err;

   logic        phy_oe = 1'b0, phy_o = 1'b1, tb_low = 1'b0;
   bit          phy_present = 1'b1;
   logic [15:0] phy_data = '0;

   pullup (mdio);
   assign mdio = tb_low ? 1'b0 : (phy_oe ? phy_o : 1'bz);

   mdio_master dut (
      .clk(clk), .rst(rst), .mdc(mdc), .mdio(mdio),
      .phy_addr(phy_addr), .reg_addr(reg_addr),
      .write_req(write_req), .write_data(write_data),
      .read_req(read_req), .read_data(read_data),
      .data_valid(data_valid), .done(done), .busy(busy), .ta_err(ta_err)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      bit          is_rd;
      logic [63:0] frame;
      logic [15:0] rdata;
      bit          ta;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0, n_pass = 0;
   int   n_done = 0, n_issued = 0;
   int   cyc = 0;
   int   last_acc = 0;
   logic [15:0] model_rd = '0;
   bit          model_ta = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [63:0] got, logic [63:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
   endtask

   function automatic logic [63:0] build(bit rd, logic [4:0] pa, logic [4:0] ra,
                                         logic [15:0] wd, bit present, logic [15:0] pd);
      if (!rd)         return {32'hFFFF_FFFF, 2'b01, 2'b01, pa, ra, 2'b10, wd};
      else if (present) return {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra, 2'b10, pd};
      else             return {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra, 2'b11, 16'hFFFF};
   endfunction

   // Monitor: captures the MDIO bitstream at each mdc rise, plays the PHY, checks at done.
   int          bit_idx = 0, run_len = 0, bad_run = 0, chg_bad = 0, idle_mdc_bad = 0;
   logic [63:0] frame_bits = '0;
   logic        mdc_q = 1'b0, busy_q = 1'b0, mdio_q = 1'b1, done_q = 1'b0;
   bit          rd_op;

   always @(negedge clk) begin
      exp_t e;
      if (!busy && mdc) idle_mdc_bad++;
      if (rst) begin
         bit_idx    = 0;
         frame_bits = '0;
         phy_oe     = 1'b0;
         run_len    = 0;
      end else begin
         if (done_q) chk("busy_after_done", busy, 0);
         if (data_valid && !done) chk("data_valid_with_done", done, 1);
         if (busy) begin
            if (mdc == mdc_q) run_len++;
            else begin
               if (run_len != 50) bad_run++;
               run_len = 1;
            end
         end
         if (busy && !busy_q) begin
            bit_idx    = 0;
            frame_bits = '0;
            run_len    = 1;
            bad_run    = 0;
            chg_bad    = 0;
            phy_oe     = 1'b0;
         end
         rd_op = (frame_bits[29] == 1'b1) && (frame_bits[28] == 1'b0);
         if (busy && mdc && mdc_q && (mdio != mdio_q) && (!rd_op || bit_idx <= 46)) chg_bad++;
         if (busy && mdc && !mdc_q) begin
            if (bit_idx < 64) frame_bits[63 - bit_idx] = mdio;
            if (rd_op && phy_present) begin
               if (bit_idx == 46) begin
                  phy_oe = 1'b1;
                  phy_o  = 1'b0;
               end else if (bit_idx >= 47 && bit_idx <= 62) begin
                  phy_o = phy_data[62 - bit_idx];
               end else if (bit_idx == 63) begin
                  phy_oe = 1'b0;
               end
            end
            bit_idx++;
         end
         if (done) begin
            n_done++;
            chk("done_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               if (e.is_rd) begin
                  model_rd = e.rdata;
                  model_ta = e.ta;
               end
               chk("latency", cyc - e.acc, 6401);
               chk("frame_bits", frame_bits, e.frame);
               chk("bit_count", bit_idx, 64);
               chk("mdc_half_periods", bad_run, 0);
               chk("mdio_stable_mdc_high", chg_bad, 0);
               chk("data_valid", data_valid, e.is_rd);
               chk("read_data", read_data, model_rd);
               chk("ta_err", ta_err, model_ta);
               chk("mdc_low_fin", mdc, 0);
            end
         end
      end
      mdc_q  = mdc;
      busy_q = busy;
      mdio_q = mdio;
      done_q = done;
   end

   task automatic issue(bit wr, bit rd, logic [4:0] pa, logic [4:0] ra, logic [15:0] wd);
      exp_t e;
      @(negedge clk);
      phy_addr   = pa;
      reg_addr   = ra;
      write_data = wd;
      write_req  = wr;
      read_req   = rd;
      e.is_rd = rd && !wr;
      e.frame = build(e.is_rd, pa, ra, wd, phy_present, phy_data);
      e.rdata = phy_present ? phy_data : 16'hFFFF;
      e.ta    = !phy_present;
      e.acc   = cyc;
      last_acc = cyc;
      exp_q.push_back(e);
      n_issued++;
      @(negedge clk);
      write_req = 1'b0;
      read_req  = 1'b0;
   endtask

   task automatic wait_done(int tgt);
      int k = 0;
      while (n_done < tgt && k < 7000) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", n_done, tgt);
   endtask

   task automatic check_released(string name);
      tb_low = 1'b1;
      #1;
      chk(name, mdio, 0);
      tb_low = 1'b0;
      #1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit          rd;
      logic [15:0] d;
      rst = 1'b1; write_req = 1'b0; read_req = 1'b0;
      phy_addr = '0; reg_addr = '0; write_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_mdc", mdc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_read_data", read_data, 0);
      chk("rst_ta_err", ta_err, 0);
      check_released("rst_mdio_z");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_released("idle_mdio_z");

      // spec write example
      issue(1'b1, 1'b0, 5'd1, 5'd0, 16'h1340);
      wait_done(n_issued);
      // spec read example
      phy_present = 1'b1; phy_data = 16'hAC00;
      issue(1'b0, 1'b1, 5'd1, 5'd17, 16'h0);
      wait_done(n_issued);
      // no PHY answering
      phy_present = 1'b0;
      issue(1'b0, 1'b1, 5'd3, 5'd2, 16'h0);
      wait_done(n_issued);
      // good read clears ta_err
      phy_present = 1'b1; phy_data = 16'($urandom);
      issue(1'b0, 1'b1, 5'($urandom), 5'($urandom), 16'h0);
      wait_done(n_issued);
      check_released("between_frames_mdio_z");
      // simultaneous requests: write wins; a read mid-frame is ignored
      issue(1'b1, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom));
      while (cyc < last_acc + 1000) @(negedge clk);
      read_req = 1'b1;
      @(negedge clk);
      read_req = 1'b0;
      wait_done(n_issued);
      // reset mid-frame
      phy_data = 16'($urandom);
      issue(1'b0, 1'b1, 5'($urandom), 5'($urandom), 16'h0);
      while (cyc < last_acc + 3000) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_mdc", mdc, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      check_released("abort_mdio_z");
      exp_q.delete();
      n_issued--;
      model_rd = '0;
      model_ta = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      chk("abort_read_data", read_data, 0);
      chk("abort_no_done", n_done, n_issued);
      // read after release
      phy_data = 16'($urandom);
      issue(1'b0, 1'b1, 5'($urandom), 5'($urandom), 16'h0);
      wait_done(n_issued);
      // randomized frames
      for (int i = 0; i < 2; i++) begin
         rd          = 1'($urandom_range(0, 1));
         phy_present = ($urandom_range(0, 3) != 0);
         phy_data    = 16'($urandom);
         d           = 16'($urandom);
         issue(!rd, rd, 5'($urandom), 5'($urandom), d);
         wait_done(n_issued);
      end
      repeat (20) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      chk("done_count", n_done, n_issued);
      chk("mdc_low_idle", idle_mdc_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
